// File: rtl/satcnt_pkg.sv
// Shared helpers for the saturating counter bank: rest level, clamped add/sub
// and default hysteresis thresholds.
package satcnt_pkg;

    localparam int SATCNT_DEF_HI_TH = 192;
    localparam int SATCNT_DEF_LO_TH = 64;

    // Midpoint of an n-bit range; idle channels decay toward it.
    function automatic int unsigned rest_value(input int unsigned n);
        return 32'd1 << (n - 32'd1);
    endfunction

    // The sum is formed one bit wider than the operands so it can never wrap.
    function automatic logic [31:0] clamp_add(input logic [31:0] a,
                                              input logic [31:0] b,
                                              input logic [31:0] max_v);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, max_v}) ? max_v : s[31:0];
    endfunction

    // A borrow out of the extra top bit means the result went below zero.
    function automatic logic [31:0] clamp_sub(input logic [31:0] a,
                                              input logic [31:0] b);
        logic [32:0] d;
        d = {1'b0, a} - {1'b0, b};
        return d[32] ? 32'd0 : d[31:0];
    endfunction

endpackage

// File: rtl/satcnt_lane.sv
// One channel of the saturating counter bank: value register, clamped
// arithmetic, decay toward rest, and registered flags derived from the next value.
module satcnt_lane
    import satcnt_pkg::*;
#(
    parameter int N      = 8,
    parameter int STEP_W = 4,
    parameter int HI_TH  = SATCNT_DEF_HI_TH,
    parameter int LO_TH  = SATCNT_DEF_LO_TH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    input  logic              dec,
    input  logic [STEP_W-1:0] step,
    input  logic              load_hit,
    input  logic [N-1:0]      load_val,
    input  logic              tick,
    output logic [N-1:0]      value,
    output logic              at_max,
    output logic              at_min,
    output logic              high
);

    localparam logic [N-1:0] REST    = N'(rest_value(N));
    localparam logic [N-1:0] MAX_VAL = {N{1'b1}};
    localparam logic [N-1:0] HI_VAL  = N'(HI_TH);
    localparam logic [N-1:0] LO_VAL  = N'(LO_TH);

    logic [N-1:0] r_value;
    logic         r_at_max;
    logic         r_at_min;
    logic         r_high;
    logic [N-1:0] w_next;
    logic         w_high_next;

    always_comb begin
        w_next = r_value;
        if (load_hit) begin
            w_next = load_val;
        end else if (inc && !dec) begin
            w_next = N'(clamp_add(32'(r_value), 32'(step), 32'(MAX_VAL)));
        end else if (dec && !inc) begin
            w_next = N'(clamp_sub(32'(r_value), 32'(step)));
        end else if (tick && !inc && !dec) begin
            // inc&dec together still counts as activity, so decay is skipped.
            if (r_value < REST) begin
                w_next = r_value + 1'b1;
            end else if (r_value > REST) begin
                w_next = r_value - 1'b1;
            end
        end
    end

    always_comb begin
        w_high_next = r_high;
        if (w_next >= HI_VAL) begin
            w_high_next = 1'b1;
        end else if (w_next <= LO_VAL) begin
            w_high_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_value  <= REST;
            r_at_max <= 1'b0;
            r_at_min <= 1'b0;
            r_high   <= 1'b0;
        end else begin
            r_value  <= w_next;
            r_at_max <= (w_next == MAX_VAL);
            r_at_min <= (w_next == '0);
            r_high   <= w_high_next;
        end
    end

    assign value  = r_value;
    assign at_max = r_at_max;
    assign at_min = r_at_min;
    assign high   = r_high;

endmodule

// File: rtl/saturating_counter_bank.sv
// Bank of CH saturating counters with shared step, per-channel load and
// hysteresis flags. Decay toward rest is built only when SATCNT_BANK_DECAY_EN is defined.
module saturating_counter_bank
    import satcnt_pkg::*;
#(
    parameter int N            = 8,
    parameter int CH           = 4,
    parameter int STEP_W       = 4,
    parameter int DECAY_PERIOD = 16,
    parameter int HI_TH        = SATCNT_DEF_HI_TH,
    parameter int LO_TH        = SATCNT_DEF_LO_TH,
    localparam int LCH_W       = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CH-1:0]     inc,
    input  logic [CH-1:0]     dec,
    input  logic [STEP_W-1:0] step,
    input  logic              load,
    input  logic [LCH_W-1:0]  load_ch,
    input  logic [N-1:0]      load_val,
    output logic [CH*N-1:0]   value,
    output logic [CH-1:0]     at_max,
    output logic [CH-1:0]     at_min,
    output logic [CH-1:0]     high
);

    logic          w_tick;
    logic [CH-1:0] w_load_hit;

    if (N < 2 || CH < 1 || DECAY_PERIOD < 1 || LO_TH >= HI_TH) begin : g_param_check
        $error("saturating_counter_bank: illegal parameter combination");
    end

`ifdef SATCNT_BANK_DECAY_EN
    localparam int PW = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DECAY_PERIOD - 1);

    logic [PW-1:0] r_presc;

    // Free-running; channel activity never restarts it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (r_presc == PRESC_LAST) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    assign w_tick = (r_presc == PRESC_LAST);
`else
    assign w_tick = 1'b0;
`endif

    for (genvar gi = 0; gi < CH; gi++) begin : g_lane
        // Codes beyond CH-1 match no lane, so out-of-range loads drop out.
        assign w_load_hit[gi] = load && (load_ch == LCH_W'(gi));

        satcnt_lane #(
            .N      (N),
            .STEP_W (STEP_W),
            .HI_TH  (HI_TH),
            .LO_TH  (LO_TH)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .inc      (inc[gi]),
            .dec      (dec[gi]),
            .step     (step),
            .load_hit (w_load_hit[gi]),
            .load_val (load_val),
            .tick     (w_tick),
            .value    (value[gi*N +: N]),
            .at_max   (at_max[gi]),
            .at_min   (at_min[gi]),
            .high     (high[gi])
        );
    end

endmodule

// File: tb/tb_saturating_counter_bank.sv
// Self-checking bench for saturating_counter_bank: directed vector table,
// decay sequences (with or without SATCNT_BANK_DECAY_EN) and randomized traffic.
module tb_saturating_counter_bank;

    localparam int P = 4;
`ifdef SATCNT_BANK_DECAY_EN
    localparam bit DECAY_EN = 1'b1;
`else
    localparam bit DECAY_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  inc, dec, step;
    logic        load;
    logic [1:0]  load_ch;
    logic [7:0]  load_val;
    logic [31:0] value;
    logic [3:0]  at_max, at_min, high;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: plain integers per channel plus edge count since reset.
    int mv[4];
    bit mh[4];
    int cyc;

    typedef struct {
        logic [3:0] inc;
        logic [3:0] dec;
        logic [3:0] stp;
        logic       ld;
        logic [1:0] ld_ch;
        logic [7:0] ld_val;
        int         ch;
        int         exp_v;
        bit         exp_h;
        bit         exp_mx;
        bit         exp_mn;
    } vec_t;

    vec_t vecs[$];

    saturating_counter_bank #(
        .N(8), .CH(4), .STEP_W(4), .DECAY_PERIOD(P), .HI_TH(192), .LO_TH(64)
    ) dut (
        .clk(clk), .rst_n(rst_n), .inc(inc), .dec(dec), .step(step),
        .load(load), .load_ch(load_ch), .load_val(load_val),
        .value(value), .at_max(at_max), .at_min(at_min), .high(high)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void chk(string name, int ch, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s ch%0d: got %0d required %0d", name, ch, got, exp);
        end
    endfunction

    function automatic int chval(int ch);
        return int'(value[ch*8 +: 8]);
    endfunction

    task automatic model_update();
        bit tick;
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                mv[i] = 128;
                mh[i] = 1'b0;
            end
            cyc = 0;
        end else begin
            tick = DECAY_EN && ((cyc % P) == P - 1);
            for (int i = 0; i < 4; i++) begin
                if (load && int'(load_ch) == i) mv[i] = int'(load_val);
                else if (inc[i] && !dec[i]) mv[i] = (mv[i] + int'(step) > 255) ? 255 : mv[i] + int'(step);
                else if (dec[i] && !inc[i]) mv[i] = (mv[i] - int'(step) < 0) ? 0 : mv[i] - int'(step);
                else if (!inc[i] && !dec[i] && tick) begin
                    if (mv[i] < 128) mv[i] = mv[i] + 1;
                    else if (mv[i] > 128) mv[i] = mv[i] - 1;
                end
                if (mv[i] >= 192) mh[i] = 1'b1;
                else if (mv[i] <= 64) mh[i] = 1'b0;
            end
            cyc++;
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 4; i++) begin
            chk("model_value", i, 32'(chval(i)), 32'(mv[i]));
            chk("model_high", i, 32'(high[i]), 32'(mh[i]));
            chk("model_at_max", i, 32'(at_max[i]), 32'(mv[i] == 255));
            chk("model_at_min", i, 32'(at_min[i]), 32'(mv[i] == 0));
        end
    endtask

    task automatic step_edge();
        model_update();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        inc = '0; dec = '0; step = '0; load = 1'b0; load_ch = '0; load_val = '0;
    endtask

    task automatic add_vec(logic [3:0] i, logic [3:0] d, logic [3:0] s, logic ld, logic [1:0] lc,
                           logic [7:0] lv, int ch, int ev, bit eh, bit emx, bit emn);
        vec_t v;
        v.inc = i; v.dec = d; v.stp = s; v.ld = ld; v.ld_ch = lc; v.ld_val = lv;
        v.ch = ch; v.exp_v = ev; v.exp_h = eh; v.exp_mx = emx; v.exp_mn = emn;
        vecs.push_back(v);
    endtask

    initial begin
        // ch0 climbs by 15 and clamps at 255
        add_vec(4'b0001, 4'b0000, 4'd15, 0, 2'd0, 8'd0, 0, 143, 0, 0, 0);
        add_vec(4'b0001, 4'b0000, 4'd15, 0, 2'd0, 8'd0, 0, 158, 0, 0, 0);
        add_vec(4'b0001, 4'b0000, 4'd15, 0, 2'd0, 8'd0, 0, 173, 0, 0, 0);
        add_vec(4'b0001, 4'b0000, 4'd15, 0, 2'd0, 8'd0, 0, 188, 0, 0, 0);
        add_vec(4'b0001, 4'b0000, 4'd15, 0, 2'd0, 8'd0, 0, 203, 1, 0, 0);
        add_vec(4'b0001, 4'b0000, 4'd15, 0, 2'd0, 8'd0, 0, 218, 1, 0, 0);
        add_vec(4'b0001, 4'b0000, 4'd15, 0, 2'd0, 8'd0, 0, 233, 1, 0, 0);
        add_vec(4'b0001, 4'b0000, 4'd15, 0, 2'd0, 8'd0, 0, 248, 1, 0, 0);
        add_vec(4'b0001, 4'b0000, 4'd15, 0, 2'd0, 8'd0, 0, 255, 1, 1, 0);
        add_vec(4'b0001, 4'b0000, 4'd15, 0, 2'd0, 8'd0, 0, 255, 1, 1, 0);
        // ch2 load 5, dec to 0 without wrap, inc+dec together holds
        add_vec(4'b0000, 4'b0000, 4'd0,  1, 2'd2, 8'd5, 2, 5, 0, 0, 0);
        add_vec(4'b0000, 4'b0100, 4'd7,  0, 2'd0, 8'd0, 2, 0, 0, 0, 1);
        add_vec(4'b0000, 4'b0100, 4'd7,  0, 2'd0, 8'd0, 2, 0, 0, 0, 1);
        add_vec(4'b0100, 4'b0100, 4'd7,  0, 2'd0, 8'd0, 2, 0, 0, 0, 1);
        // ch1 hysteresis: set at 192, hold at 100, clear at 64
        add_vec(4'b0010, 4'b0000, 4'd15, 0, 2'd0, 8'd0, 1, 143, 0, 0, 0);
        add_vec(4'b0010, 4'b0000, 4'd15, 0, 2'd0, 8'd0, 1, 158, 0, 0, 0);
        add_vec(4'b0010, 4'b0000, 4'd15, 0, 2'd0, 8'd0, 1, 173, 0, 0, 0);
        add_vec(4'b0010, 4'b0000, 4'd15, 0, 2'd0, 8'd0, 1, 188, 0, 0, 0);
        add_vec(4'b0010, 4'b0000, 4'd4,  0, 2'd0, 8'd0, 1, 192, 1, 0, 0);
        add_vec(4'b0000, 4'b0010, 4'd15, 0, 2'd0, 8'd0, 1, 177, 1, 0, 0);
        add_vec(4'b0000, 4'b0010, 4'd15, 0, 2'd0, 8'd0, 1, 162, 1, 0, 0);
        add_vec(4'b0000, 4'b0010, 4'd15, 0, 2'd0, 8'd0, 1, 147, 1, 0, 0);
        add_vec(4'b0000, 4'b0010, 4'd15, 0, 2'd0, 8'd0, 1, 132, 1, 0, 0);
        add_vec(4'b0000, 4'b0010, 4'd15, 0, 2'd0, 8'd0, 1, 117, 1, 0, 0);
        add_vec(4'b0000, 4'b0010, 4'd15, 0, 2'd0, 8'd0, 1, 102, 1, 0, 0);
        add_vec(4'b0000, 4'b0010, 4'd2,  0, 2'd0, 8'd0, 1, 100, 1, 0, 0);
        add_vec(4'b0000, 4'b0010, 4'd15, 0, 2'd0, 8'd0, 1, 85,  1, 0, 0);
        add_vec(4'b0000, 4'b0010, 4'd15, 0, 2'd0, 8'd0, 1, 70,  1, 0, 0);
        add_vec(4'b0000, 4'b0010, 4'd6,  0, 2'd0, 8'd0, 1, 64,  0, 0, 0);
        add_vec(4'b0010, 4'b0000, 4'd0,  0, 2'd0, 8'd0, 1, 64,  0, 0, 0);

        rst_n = 1'b0;
        idle();
        repeat (3) step_edge();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("reset_value", i, 32'(chval(i)), 32'd128);
            chk("reset_flags", i, {29'd0, at_max[i], at_min[i], high[i]}, 32'd0);
        end

        foreach (vecs[k]) begin
            inc = vecs[k].inc; dec = vecs[k].dec; step = vecs[k].stp;
            load = vecs[k].ld; load_ch = vecs[k].ld_ch; load_val = vecs[k].ld_val;
            step_edge();
            chk("vec_value", vecs[k].ch, 32'(chval(vecs[k].ch)), 32'(vecs[k].exp_v));
            chk("vec_high", vecs[k].ch, 32'(high[vecs[k].ch]), 32'(vecs[k].exp_h));
            chk("vec_at_max", vecs[k].ch, 32'(at_max[vecs[k].ch]), 32'(vecs[k].exp_mx));
            chk("vec_at_min", vecs[k].ch, 32'(at_min[vecs[k].ch]), 32'(vecs[k].exp_mn));
            $display("vec %0d: ch%0d value=%0d high=%0b", k, vecs[k].ch, chval(vecs[k].ch), high[vecs[k].ch]);
        end
        idle();

        // ch3 decay sequence
        load = 1'b1; load_ch = 2'd3; load_val = 8'd131;
        step_edge();
        idle();
        chk("load_ch3", 3, 32'(chval(3)), 32'd131);
`ifdef SATCNT_BANK_DECAY_EN
        for (int k = 0; k < P + 1 && chval(3) == 131; k++) step_edge();
        chk("decay_first_tick", 3, 32'(chval(3)), 32'd130);
        repeat (P) step_edge();
        chk("decay_second_tick", 3, 32'(chval(3)), 32'd129);
        repeat (P) step_edge();
        chk("decay_reach_rest", 3, 32'(chval(3)), 32'd128);
        repeat (2 * P) step_edge();
        chk("decay_hold_rest", 3, 32'(chval(3)), 32'd128);
        for (int k = 0; k < P && (cyc % P) != P - 1; k++) step_edge();
        step_edge();
        load = 1'b1; load_ch = 2'd3; load_val = 8'd131;
        step_edge();
        idle();
        repeat (P - 2) step_edge();
        chk("pre_tick_hold", 3, 32'(chval(3)), 32'd131);
        inc = 4'b1000; step = 4'd0;
        step_edge();
        idle();
        chk("decay_suppressed", 3, 32'(chval(3)), 32'd131);
        repeat (P) step_edge();
        chk("decay_after_suppress", 3, 32'(chval(3)), 32'd130);
`else
        repeat (5 * P) step_edge();
        chk("no_decay_hold", 3, 32'(chval(3)), 32'd131);
`endif

        // Out-of-range load_ch does not exist for CH=4; randomized traffic with one mid-run reset.
        for (int k = 0; k < 400; k++) begin
            inc = 4'($urandom); dec = 4'($urandom);
            step = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
            load = ($urandom_range(0, 7) == 0);
            load_ch = 2'($urandom); load_val = 8'($urandom);
            if (k % 16 == 0) begin
                inc = '0; dec = '0;
            end
            rst_n = (k != 200);
            step_edge();
            if (k == 200) begin
                for (int i = 0; i < 4; i++) chk("midrun_reset", i, 32'(chval(i)), 32'd128);
            end
            if (k % 50 == 0) $display("rand %0d: value=%08h high=%04b", k, value, high);
        end
        rst_n = 1'b1;
        idle();
        step_edge();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/saturating_counter_bank.md
# saturating_counter_bank

Bank of `CH` independent N-bit saturating counters with a programmable step size, per-channel load, optional decay toward a rest value, and hysteresis threshold flags. It is the multi-channel successor to the single saturating counter and holds several internal "mood" levels in one block. Downstream logic reads the packed values and the per-channel flags directly.

## Interface
- `N`, 8: counter width per channel (≥2).
- `CH`, 4: number of channels (≥1).
- `STEP_W`, 4: width of step magnitude.
- `DECAY_PERIOD`, 16: cycles between decay ticks (≥1).
- `HI_TH`, 192: high-flag set threshold.
- `LO_TH`, 64: high-flag clear threshold (must be < HI_TH).

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `inc` in CH: per-channel increment request.
- `dec` in CH: per-channel decrement request.
- `step` in STEP_W: step magnitude shared by all channels; 0 means no change.
- `load` in 1: load strobe.
- `load_ch` in $clog2(CH) (min 1): channel to load.
- `load_val` in N: value to load.
- `value` out CH*N: packed counters; channel i at [i*N +: N].
- `at_max` out CH: channel value == 2^N−1.
- `at_min` out CH: channel value == 0.
- `high` out CH: hysteresis flag.

## Operation
- REST = 2^(N−1). Reset: every value = REST, at_max = 0, at_min = 0, high = 0, decay prescaler = 0.
- Per-channel priority, evaluated every cycle: load hit > inc/dec > decay > hold.
- Load hit: `load` && `load_ch`==i sets value = `load_val`. Out-of-range `load_ch` is ignored.
- `{inc,dec}`:
  - 10: value = min(value+step, 2^N−1).
  - 01: value = max(value−step, 0).
  - 11 or 00: no arithmetic.
- Arithmetic is done at N+1 bits, then clamped. The counter never wraps.
- Activity = inc|dec on that channel, or a load hit. Activity suppresses decay for that channel in that cycle.
- Decay (macro only): the prescaler counts 0..DECAY_PERIOD−1 and wraps; `tick` is asserted when the count == DECAY_PERIOD−1. On `tick`, each inactive channel moves 1 toward REST; a channel already at REST holds.
- `high` is set when the next value ≥ HI_TH and cleared when the next value ≤ LO_TH; otherwise it holds. A load also obeys these rules.
- at_max and at_min are derived from the next value.

## Timing
- Latency is 1 cycle: inputs sampled at edge k appear on `value` and the flags after edge k. Flags are always coherent with `value` in the same cycle.
- There is no handshake. Requests are level-sampled every cycle, so a held `inc` steps every cycle.
- The prescaler runs freely and is not reset by activity. The first tick comes DECAY_PERIOD cycles after reset release.
- Reset asserted mid-operation overrides everything at the next edge.

## Configuration
- `SATCNT_BANK_DECAY_EN`:
  - Defined: the prescaler and decay toward REST are built.
  - Undefined: no prescaler, idle channels hold indefinitely, and DECAY_PERIOD is unused.

## Structure
- Package `satcnt_pkg`: the REST computation function, the clamp-add/clamp-sub functions, and the default threshold constants.
- Sub-module `satcnt_lane` holds one channel (register, clamp logic, flags). It is instantiated CH times in a generate loop. The top holds the prescaler and the load decode.

## Test plan
All scenarios use N=8, CH=4, STEP_W=4.
- Reset, then sample → every value = 128, all flags 0.
- ch0 inc, step=15, held for 9 cycles → 143, 158, …, 248, then 255 clamped; at_max[0]=1 and value holds at 255 on further incs.
- load ch2=5, then dec with step=7 → 0 (no wrap), at_min[2]=1; inc and dec together → value unchanged.
- ch1 inc to 192 → high=1; dec to 100 → high stays 1; dec to 64 → high=0.
- With `SATCNT_BANK_DECAY_EN`, DECAY_PERIOD=4: load ch3=131, then idle → 130 after the next tick, 129 four cycles later, 128, then holds. A ch3 inc in a tick cycle suppresses decay for that tick.
- Same sequence without the macro → ch3 holds at 131 indefinitely.
